// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB LED sequencer.
package rgb_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Channel positions on rgb_pwm (bit0=R, bit1=G, bit2=B)
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // PWM period length in cycles for a given duty width: 2^bits - 1
  function automatic int unsigned pwm_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: holds the active duty, compares it against the shared
// timebase and registers the result so the pin never glitches.
module rgb_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic                active_i,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] duty_q;
  logic                pwm_q;

  // Duty register: only reloaded when the sequencer allows (IDLE or period end)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (load_i) begin
      duty_q <= duty_i;
    end
  end

  // Registered compare: high while the timebase is below the duty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= active_i && (cnt_i < duty_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_seq_ctrl.sv
// RGB LED sequencer: steps a programmable colour/hold table, owns the PWM
// timebase and drives the SB_RGBA_DRV PWM and enable inputs.
module rgb_seq_ctrl
  import rgb_seq_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int HOLD_BITS = 16,
  parameter int NUM_STEPS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_idx,
  input  logic [3*PWM_BITS-1:0]        cfg_rgb,
  input  logic [HOLD_BITS-1:0]         cfg_hold,
  output logic [2:0]                   rgb_pwm,
  output logic                         led_en,
  output logic                         curr_en,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         step_tick
);

  localparam int IDX_BITS = $clog2(NUM_STEPS);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(pwm_max(PWM_BITS) - 32'd1);

  state_e                state_q, state_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [HOLD_BITS-1:0]  hold_q, hold_d;
  logic [IDX_BITS-1:0]   step_idx_q, step_idx_d, idx_inc_s;
  logic [3*PWM_BITS-1:0] tab_rgb_q [NUM_STEPS];
  logic [3*PWM_BITS-1:0] tab_rgb_d [NUM_STEPS];
  logic [HOLD_BITS-1:0]  tab_hold_q [NUM_STEPS];
  logic [HOLD_BITS-1:0]  tab_hold_d [NUM_STEPS];
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  led_en_q, step_tick_q;
  logic                  active_s, period_end_s, advance_s, load_s;
  logic [3*PWM_BITS-1:0] duty_next_s;

  assign active_s     = (state_q != IDLE);
  assign period_end_s = active_s && (pwm_cnt_q == CNT_LAST);
  assign idx_inc_s    = step_idx_q + 1'b1;

  // Next-state logic of the sequencer FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;   else state_d = IDLE;
      RUN:     if (!en) state_d = DRAIN; else state_d = RUN;
      DRAIN: begin
        if (en)                state_d = RUN;
        else if (period_end_s) state_d = IDLE;
        else                   state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Table write port; cfg_ready is low on period ends so writes never race a reload
  always_comb begin
    tab_rgb_d  = tab_rgb_q;
    tab_hold_d = tab_hold_q;
    if (cfg_valid && cfg_ready_q) begin
      tab_rgb_d[cfg_idx]  = cfg_rgb;
      tab_hold_d[cfg_idx] = cfg_hold;
    end else begin
      tab_rgb_d  = tab_rgb_q;
      tab_hold_d = tab_hold_q;
    end
  end

  // Timebase, hold counter and step advance; hold 0 behaves like hold 1
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q;
    step_idx_d = step_idx_q;
    hold_d     = hold_q;
    load_s     = 1'b0;
    advance_s  = 1'b0;
    if ((state_d == IDLE) || (state_q == IDLE)) begin
      pwm_cnt_d  = '0;
      step_idx_d = '0;
      hold_d     = tab_hold_d[0];
      load_s     = 1'b1;
    end else if (period_end_s) begin
      pwm_cnt_d = '0;
      load_s    = 1'b1;
      if (hold_q <= HOLD_BITS'(1)) begin
        advance_s  = 1'b1;
        step_idx_d = idx_inc_s;
        hold_d     = tab_hold_d[idx_inc_s];
      end else begin
        hold_d = hold_q - HOLD_BITS'(1);
      end
    end else begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
    cfg_ready_d = !((state_d != IDLE) && (pwm_cnt_d == CNT_LAST));
  end

  assign duty_next_s = tab_rgb_d[step_idx_d];

  // Sequencer state, counters, table and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pwm_cnt_q   <= '0;
      hold_q      <= '0;
      step_idx_q  <= '0;
      cfg_ready_q <= 1'b1;
      led_en_q    <= 1'b0;
      step_tick_q <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        tab_rgb_q[i]  <= '0;
        tab_hold_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pwm_cnt_q   <= pwm_cnt_d;
      hold_q      <= hold_d;
      step_idx_q  <= step_idx_d;
      cfg_ready_q <= cfg_ready_d;
      led_en_q    <= (state_d != IDLE);
      step_tick_q <= advance_s;
      tab_rgb_q   <= tab_rgb_d;
      tab_hold_q  <= tab_hold_d;
    end
  end

  // Three PWM channels; R takes the MSB duty field
  for (genvar c = CH_R; c <= CH_B; c++) begin : g_ch
    rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load_s),
      .duty_i   (duty_next_s[(2-c)*PWM_BITS +: PWM_BITS]),
      .cnt_i    (pwm_cnt_q),
      .active_i (active_s),
      .pwm_o    (rgb_pwm[c])
    );
  end

  assign cfg_ready = cfg_ready_q;
  assign led_en    = led_en_q;
  assign curr_en   = led_en_q;
  assign step_idx  = step_idx_q;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Scoreboard bench for rgb_seq_ctrl: a period-level reference model predicts
// every output cycle; a monitor compares; directed checks cover test-plan items.
module tb_rgb_seq_ctrl;

  localparam int NS   = 4;
  localparam int PMAX = 255;

  logic        clk = 1'b0;
  logic        rst_n, en, cfg_valid, cfg_ready;
  logic [1:0]  cfg_idx, step_idx;
  logic [23:0] cfg_rgb;
  logic [15:0] cfg_hold;
  logic [2:0]  rgb_pwm;
  logic        led_en, curr_en, step_tick;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  // reference model: mode 0=off, 1=running, 2=finishing the period
  int m_mode, m_cnt, m_idx, m_left;
  int m_duty [3];
  int m_tab_duty [NS][3];
  int m_tab_hold [NS];
  logic [8:0] m_out;

  rgb_seq_ctrl #(.PWM_BITS(8), .HOLD_BITS(16), .NUM_STEPS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_rgb(cfg_rgb), .cfg_hold(cfg_hold), .rgb_pwm(rgb_pwm),
    .led_en(led_en), .curr_en(curr_en), .step_idx(step_idx), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_idx = 0; m_left = 1;
    for (int c = 0; c < 3; c++) m_duty[c] = 0;
    for (int i = 0; i < NS; i++) begin
      m_tab_hold[i] = 0;
      for (int c = 0; c < 3; c++) m_tab_duty[i][c] = 0;
    end
    m_out = {1'b1, 8'b0};
  endtask

  function automatic int at_least_one(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  // advance the model by one clock given the inputs applied this cycle
  task automatic model_step(input logic r, input logic e, input logic v, input int idx,
                            input logic [23:0] rgb, input int hold);
    int nmode;
    logic [2:0] pw;
    logic tick, pe;
    if (!r) begin
      model_reset();
    end else begin
      for (int c = 0; c < 3; c++) pw[c] = (m_mode != 0) && (m_cnt < m_duty[c]);
      if (v && m_out[8]) begin
        m_tab_duty[idx][0] = int'(rgb[23:16]);
        m_tab_duty[idx][1] = int'(rgb[15:8]);
        m_tab_duty[idx][2] = int'(rgb[7:0]);
        m_tab_hold[idx]    = hold;
      end
      pe = (m_mode != 0) && (m_cnt == PMAX - 1);
      if (m_mode == 0)      nmode = e ? 1 : 0;
      else if (m_mode == 1) nmode = e ? 1 : 2;
      else                  nmode = e ? 1 : (pe ? 0 : 2);
      tick = 1'b0;
      if (nmode == 0 || m_mode == 0) begin
        m_cnt = 0; m_idx = 0;
        m_left = at_least_one(m_tab_hold[0]);
        for (int c = 0; c < 3; c++) m_duty[c] = m_tab_duty[0][c];
      end else if (pe) begin
        m_cnt = 0;
        m_left--;
        if (m_left == 0) begin
          m_idx  = (m_idx + 1) % NS;
          m_left = at_least_one(m_tab_hold[m_idx]);
          tick   = 1'b1;
        end
        for (int c = 0; c < 3; c++) m_duty[c] = m_tab_duty[m_idx][c];
      end else begin
        m_cnt++;
      end
      m_mode = nmode;
      m_out = {!(nmode != 0 && m_cnt == PMAX - 1), tick, 2'(m_idx),
               (nmode != 0), (nmode != 0), pw};
    end
    exp_q.push_back(m_out);
  endtask

  // drive one cycle of inputs at the falling edge and record the prediction
  task automatic cyc(input logic r, input logic e, input logic v, input int idx,
                     input logic [23:0] rgb, input int hold);
    @(negedge clk);
    rst_n = r; en = e; cfg_valid = v; cfg_idx = 2'(idx); cfg_rgb = rgb; cfg_hold = 16'(hold);
    model_step(r, e, v, idx, rgb, hold);
  endtask

  function automatic logic [7:0] rand_duty();
    int s;
    s = $urandom_range(0, 3);
    if (s == 0) return 8'd0;
    if (s == 1) return 8'd255;
    return 8'($urandom_range(0, 255));
  endfunction

  // monitor: compare every post-edge output bundle against the scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("outputs", {cfg_ready, step_tick, step_idx, curr_en, led_en, rgb_pwm}, mon_exp);
      end
    end
  end

  initial begin
    int cnt_r, cnt_g, cnt_b, n, k;
    int ticks[$];
    int tidx[$];
    logic ev;
    model_reset();
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_idx = 2'd0; cfg_rgb = 24'd0; cfg_hold = 16'd0;
    cyc(1'b0, 1'b0, 1'b0, 0, 24'd0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0, 24'd0, 0);

    // reset with en low, held 100 cycles
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0, 0, 24'd0, 0);
    check("idle_state", {cfg_ready, led_en, curr_en, step_idx, rgb_pwm, step_tick}, {1'b1, 8'd0});

    // steady colour {255,128,0}: duty extremes and exact G count
    for (int i = 0; i < NS; i++) cyc(1'b1, 1'b0, 1'b1, i, 24'hFF8000, 1);
    cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0);
    check("led_en_rise", {led_en, rgb_pwm}, 4'b1000);
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0);
      cnt_r += int'(rgb_pwm[0]); cnt_g += int'(rgb_pwm[1]); cnt_b += int'(rgb_pwm[2]);
    end
    check("r_count", cnt_r, 255);
    check("g_count", cnt_g, 128);
    check("b_count", cnt_b, 0);

    // back to idle, then program the stepping table
    k = 0;
    while (m_mode != 0 && k < 600) begin cyc(1'b1, 1'b0, 1'b0, 0, 24'd0, 0); k++; end
    cyc(1'b1, 1'b0, 1'b0, 0, 24'd0, 0);
    check("idle_reached", led_en, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 0, 24'h0A0000, 1);
    cyc(1'b1, 1'b0, 1'b1, 1, 24'h001400, 2);
    cyc(1'b1, 1'b0, 1'b1, 2, 24'h00001E, 1);
    cyc(1'b1, 1'b0, 1'b1, 3, 24'h000000, 1);
    cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0);
    for (int t = 0; t < 1300; t++) begin
      cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0);
      if (step_tick) begin ticks.push_back(t); tidx.push_back(int'(step_idx)); end
    end
    check("tick_count", ticks.size(), 4);
    if (ticks.size() == 4) begin
      check("tick0_cycle", ticks[0], 255);  check("tick0_idx", tidx[0], 1);
      check("tick1_cycle", ticks[1], 765);  check("tick1_idx", tidx[1], 2);
      check("tick2_cycle", ticks[2], 1020); check("tick2_idx", tidx[2], 3);
      check("tick3_cycle", ticks[3], 1275); check("tick3_idx", tidx[3], 0);
    end

    // drop en at pwm_cnt=100: period finishes at 254, led_en then falls
    k = 0;
    while (!(m_mode == 1 && m_cnt == 100) && k < 300) begin cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0); k++; end
    cyc(1'b1, 1'b0, 1'b0, 0, 24'd0, 0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 0, 24'd0, 0);
      if (led_en) n++;
      else break;
    end
    check("drain_len", n, 154);
    check("drain_idle_pwm", rgb_pwm, 3'b000);

    // cfg_valid held across a period end
    k = 0;
    while (!(m_mode == 1 && m_cnt == 254) && k < 600) begin cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0); k++; end
    cyc(1'b1, 1'b1, 1'b1, m_idx, 24'hC8C8C8, 2);
    check("ready_low_at_end", cfg_ready, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, m_idx, 24'hC8C8C8, 2);
    check("ready_after_end", cfg_ready, 1'b1);
    for (int i = 0; i < 600; i++) cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0);

    // async reset mid-run with duty 200
    k = 0;
    while (m_mode != 0 && k < 600) begin cyc(1'b1, 1'b0, 1'b0, 0, 24'd0, 0); k++; end
    for (int i = 0; i < NS; i++) cyc(1'b1, 1'b0, 1'b1, i, 24'hC8C8C8, 5);
    k = 0;
    while (!(m_mode == 1 && m_cnt == 50) && k < 300) begin cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0); k++; end
    check("pwm_before_reset", rgb_pwm, 3'b111);
    cyc(1'b0, 1'b1, 1'b0, 0, 24'd0, 0);
    #1;
    check("async_reset", {rgb_pwm, led_en, curr_en, step_idx, step_tick, cfg_ready}, 9'b000000001);
    cyc(1'b0, 1'b1, 1'b0, 0, 24'd0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0);
    ev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 0, 24'd0, 0);
      if (rgb_pwm != 3'b000) ev = 1'b1;
    end
    check("table_cleared", ev, 1'b0);

    // randomized run against the model
    ev = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 149) == 0) ev = !ev;
      cyc(1'b1, ev, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
          {rand_duty(), rand_duty(), rand_duty()}, int'($urandom_range(0, 3)));
    end

    cyc(1'b1, 1'b0, 1'b0, 0, 24'd0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
